// File: rtl/control_pkg.sv
// Shared definitions for the pipelined RV32I control unit: opcodes, ULA
// operation classes and the per-stage control bundle.
package control_pkg;

    localparam int CTRL_RD_W = 5;
    localparam int CTRL_OP_W = 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CTRL_OP_W-1:0] ULA_OP_ADD    = 2'b00;
    localparam logic [CTRL_OP_W-1:0] ULA_OP_BRANCH = 2'b01;
    localparam logic [CTRL_OP_W-1:0] ULA_OP_R      = 2'b10;
    localparam logic [CTRL_OP_W-1:0] ULA_OP_I      = 2'b11;

    typedef struct packed {
        logic                 mux_ula;
        logic [CTRL_OP_W-1:0] ula_op;
        logic                 branch;
        logic                 jump;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 reg_wr;
        logic                 mux_reg_wr;
        logic [CTRL_RD_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational ID-stage decoder: instruction -> control bundle, source
// register usage flags and illegal-opcode detection.
module control_decode
    import control_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [INSTR_W-1:0]    instruction,
    output ctrl_t                 ctrl,
    output logic                  use_rs1,
    output logic                  use_rs2,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic                  illegal
);

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd_field;
    logic                  unused_bits;

    assign opcode      = instruction[6:0];
    assign rd_field    = instruction[11:7];
    assign rs1         = instruction[19:15];
    assign rs2         = instruction[24:20];
    assign unused_bits = ^{instruction[INSTR_W-1:25], instruction[14:12]};

    always_comb begin
        ctrl    = CTRL_NOP;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_R: begin
                    ctrl.ula_op     = ULA_OP_R;
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mux_reg_wr = 1'b1;
                    ctrl.rd         = rd_field;
                    use_rs1         = 1'b1;
                    use_rs2         = 1'b1;
                end
                OP_I: begin
                    ctrl.mux_ula    = 1'b1;
                    ctrl.ula_op     = ULA_OP_I;
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mux_reg_wr = 1'b1;
                    ctrl.rd         = rd_field;
                    use_rs1         = 1'b1;
                end
                OP_LOAD: begin
                    ctrl.mux_ula = 1'b1;
                    ctrl.ula_op  = ULA_OP_ADD;
                    ctrl.mem_rd  = 1'b1;
                    ctrl.reg_wr  = 1'b1;
                    ctrl.rd      = rd_field;
                    use_rs1      = 1'b1;
                end
                OP_STORE: begin
                    ctrl.mux_ula = 1'b1;
                    ctrl.ula_op  = ULA_OP_ADD;
                    ctrl.mem_wr  = 1'b1;
                    use_rs1      = 1'b1;
                    use_rs2      = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl.ula_op = ULA_OP_BRANCH;
                    ctrl.branch = 1'b1;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    ctrl.mux_ula    = 1'b1;
                    ctrl.ula_op     = ULA_OP_ADD;
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mux_reg_wr = 1'b1;
                    ctrl.rd         = rd_field;
                end
                OP_JAL: begin
                    ctrl.mux_ula    = 1'b1;
                    ctrl.ula_op     = ULA_OP_ADD;
                    ctrl.jump       = 1'b1;
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mux_reg_wr = 1'b1;
                    ctrl.rd         = rd_field;
                end
                default: illegal = 1'b1;
            endcase
        end
        // Writes to x0 are architecturally discarded, so never request one.
        if (ctrl.rd == '0) ctrl.reg_wr = 1'b0;
    end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit: decodes ID, carries the bundle through EX/MEM/WB,
// stalls on load-use and zeroes the next EX bundle on a resolved branch/jump.
module control_pipe
    import control_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ULA_OP_W   = 2,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  ex_flush,
    output logic                  id_stall,
    output logic                  ex_mux_ula,
    output logic [ULA_OP_W-1:0]   ex_ula_op,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic                  wb_reg_wr,
    output logic                  wb_mux_reg_wr,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal
);

    ctrl_t                 id_ctrl;
    ctrl_t                 ex_q;
    ctrl_t                 mem_q;
    ctrl_t                 wb_q;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  load_use;
    logic                  unused_fields;

    control_decode #(
        .INSTR_W    (INSTR_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .id_valid    (id_valid),
        .instruction (instruction),
        .ctrl        (id_ctrl),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .rs1         (rs1),
        .rs2         (rs2),
        .illegal     (illegal)
    );

    assign load_use = (HAZARD_EN != 0) && id_valid && ex_q.mem_rd && (ex_q.rd != '0)
                    && ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd)));

    // A flush discards the ID instruction anyway, so holding fetch would be wrong.
    assign id_stall = load_use && !ex_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= CTRL_NOP;
            mem_q <= CTRL_NOP;
            wb_q  <= CTRL_NOP;
        end else begin
            ex_q  <= (ex_flush || load_use) ? CTRL_NOP : id_ctrl;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_mux_ula    = ex_q.mux_ula;
    assign ex_ula_op     = ex_q.ula_op;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_rd         = ex_q.rd;
    assign mem_rd        = mem_q.mem_rd;
    assign mem_wr        = mem_q.mem_wr;
    assign mem_rd_addr   = mem_q.rd;
    assign wb_reg_wr     = wb_q.reg_wr;
    assign wb_mux_reg_wr = wb_q.mux_reg_wr;
    assign wb_rd         = wb_q.rd;

    // Each stage only consumes its own slice of the bundle.
    assign unused_fields = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: a queue-based pipeline model checked every
// cycle, plus hand-computed expectations at the scenario points of interest.
module tb_control_pipe;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] instruction;
    logic        ex_flush;
    logic        id_stall;
    logic        ex_mux_ula;
    logic [1:0]  ex_ula_op;
    logic        ex_branch;
    logic        ex_jump;
    logic [4:0]  ex_rd;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  mem_rd_addr;
    logic        wb_reg_wr;
    logic        wb_mux_reg_wr;
    logic [4:0]  wb_rd;
    logic        illegal;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    // Expected bundle: {mux_ula, ula_op[1:0], branch, jump, mem_rd, mem_wr,
    // reg_wr, mux_reg_wr, rd[4:0]}; exp_q[0]=EX, [1]=MEM, [2]=WB.
    logic [13:0] exp_q[$] = '{14'd0, 14'd0, 14'd0};

    control_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .instruction   (instruction),
        .ex_flush      (ex_flush),
        .id_stall      (id_stall),
        .ex_mux_ula    (ex_mux_ula),
        .ex_ula_op     (ex_ula_op),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_rd_addr   (mem_rd_addr),
        .wb_reg_wr     (wb_reg_wr),
        .wb_mux_reg_wr (wb_mux_reg_wr),
        .wb_rd         (wb_rd),
        .illegal       (illegal)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [13:0] model_bundle(input logic v, input logic [31:0] ins);
        logic [8:0] t;
        logic [4:0] rd;
        t = '0;
        if (v) begin
            case (ins[6:0])
                7'b0110011: t = 9'b0_10_0_0_0_0_1_1;
                7'b0010011: t = 9'b1_11_0_0_0_0_1_1;
                7'b0000011: t = 9'b1_00_0_0_1_0_1_0;
                7'b0100011: t = 9'b1_00_0_0_0_1_0_0;
                7'b1100011: t = 9'b0_01_1_0_0_0_0_0;
                7'b0110111, 7'b0010111: t = 9'b1_00_0_0_0_0_1_1;
                7'b1101111: t = 9'b1_00_0_1_0_0_1_1;
                default: t = '0;
            endcase
        end
        rd = t[1] ? ins[11:7] : 5'd0;
        if (rd == 5'd0) t[1] = 1'b0;
        return {t, rd};
    endfunction

    function automatic logic model_illegal(input logic v, input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
            default: return v;
        endcase
    endfunction

    function automatic logic model_stall(input logic v, input logic [31:0] ins,
                                         input logic fl, input logic [13:0] ex);
        logic r1, r2;
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin r1 = 1'b1; r2 = 1'b1; end
            7'b0010011, 7'b0000011:             begin r1 = 1'b1; r2 = 1'b0; end
            default:                            begin r1 = 1'b0; r2 = 1'b0; end
        endcase
        return v && !fl && ex[8] && (ex[4:0] != 5'd0)
            && ((r1 && ins[19:15] == ex[4:0]) || (r2 && ins[24:20] == ex[4:0]));
    endfunction

    always @(posedge clk) begin
        logic [13:0] nb;
        logic        raw_hazard;
        if (!rst_n) begin
            exp_q = '{14'd0, 14'd0, 14'd0};
        end else begin
            raw_hazard = model_stall(id_valid, instruction, 1'b0, exp_q[0]);
            nb = (ex_flush || raw_hazard) ? 14'd0 : model_bundle(id_valid, instruction);
            exp_q.push_front(nb);
            void'(exp_q.pop_back());
        end
        started = 1'b1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("cmp_ex", {22'd0, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd},
                  {22'd0, exp_q[0][13:9], exp_q[0][4:0]});
            check("cmp_mem", {25'd0, mem_rd, mem_wr, mem_rd_addr},
                  {25'd0, exp_q[1][8:7], exp_q[1][4:0]});
            check("cmp_wb", {25'd0, wb_reg_wr, wb_mux_reg_wr, wb_rd},
                  {25'd0, exp_q[2][6:5], exp_q[2][4:0]});
            check("cmp_stall", {31'd0, id_stall},
                  {31'd0, model_stall(id_valid, instruction, ex_flush, exp_q[0])});
            check("cmp_illegal", {31'd0, illegal},
                  {31'd0, model_illegal(id_valid, instruction)});
        end
    end

    // ---------------- driver ----------------
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        @(posedge clk);
        #1;
        id_valid    = v;
        instruction = ins;
        ex_flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0);
    endtask

    logic [31:0] i_add, i_lw5, i_use5, i_addi, i_lw0, i_use0, i_beq, i_sw, i_bad, i_addi1;

    initial begin
        i_add   = enc(7'b0110011, 5'd3, 5'd1, 5'd2);
        i_lw5   = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
        i_use5  = enc(7'b0110011, 5'd6, 5'd5, 5'd2);
        i_addi  = enc(7'b0010011, 5'd7, 5'd8, 5'd1);
        i_lw0   = enc(7'b0000011, 5'd0, 5'd1, 5'd0);
        i_use0  = enc(7'b0110011, 5'd9, 5'd0, 5'd0);
        i_beq   = enc(7'b1100011, 5'd0, 5'd1, 5'd2);
        i_sw    = enc(7'b0100011, 5'd4, 5'd1, 5'd2);
        i_bad   = {25'd0, 7'b1111111};
        i_addi1 = enc(7'b0010011, 5'd1, 5'd0, 5'd1);

        rst_n = 1'b0; id_valid = 1'b0; instruction = 32'd0; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("reset_wb", {30'd0, wb_reg_wr, wb_mux_reg_wr}, 32'd0);

        // 1: add x3,x1,x2
        drive(1'b1, i_add, 1'b0);
        idle(); #1;
        check("t1_ex_ula_op", {30'd0, ex_ula_op}, 32'd2);
        idle();
        idle(); #1;
        check("t1_wb", {25'd0, wb_reg_wr, wb_mux_reg_wr, wb_rd}, {25'd0, 2'b11, 5'd3});

        // 2: lw x5 ; add x6,x5,x2 -> one stall cycle
        drive(1'b1, i_lw5, 1'b0);
        drive(1'b1, i_use5, 1'b0); #1;
        check("t2_stall", {31'd0, id_stall}, 32'd1);
        drive(1'b1, i_use5, 1'b0); #1;
        check("t2_stall_once", {31'd0, id_stall}, 32'd0);
        check("t2_bubble", {27'd0, ex_rd}, 32'd0);
        check("t2_lw_mem", {26'd0, mem_rd, mem_rd_addr}, {26'd0, 1'b1, 5'd5});
        idle(); #1;
        check("t2_add_late", {25'd0, ex_ula_op, ex_rd}, {25'd0, 2'b10, 5'd6});

        // 3: no-match and x0 loads never stall
        drive(1'b1, i_lw5, 1'b0);
        drive(1'b1, i_addi, 1'b0); #1;
        check("t3_nomatch", {31'd0, id_stall}, 32'd0);
        drive(1'b1, i_lw0, 1'b0);
        drive(1'b1, i_use0, 1'b0); #1;
        check("t3_x0", {31'd0, id_stall}, 32'd0);

        // 4: flush beats a pending load-use stall
        drive(1'b1, i_lw5, 1'b0);
        drive(1'b1, i_use5, 1'b1); #1;
        check("t4_no_stall", {31'd0, id_stall}, 32'd0);
        idle(); #1;
        check("t4_ex_zero", {22'd0, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd}, 32'd0);
        drive(1'b1, i_beq, 1'b0);
        drive(1'b1, i_add, 1'b1); #1;
        check("t4_beq_ex", {30'd0, ex_branch, ex_mux_ula}, 32'd2);
        idle(); #1;
        check("t4_flushed", {22'd0, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd}, 32'd0);

        // 5: store and illegal opcode
        drive(1'b1, i_sw, 1'b0);
        idle();
        idle(); #1;
        check("t5_mem", {30'd0, mem_wr, mem_rd}, 32'd2);
        idle(); #1;
        check("t5_wb", {31'd0, wb_reg_wr}, 32'd0);
        drive(1'b1, i_bad, 1'b0); #1;
        check("t5_illegal", {31'd0, illegal}, 32'd1);
        drive(1'b0, i_bad, 1'b0); #1;
        check("t5_illegal_inv", {31'd0, illegal}, 32'd0);
        check("t5_zero", {22'd0, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd}, 32'd0);

        // 6: reset during a stall with the pipe full
        drive(1'b1, i_addi1, 1'b0);
        drive(1'b1, i_lw5, 1'b0);
        drive(1'b1, i_use5, 1'b0); #1;
        check("t6_stall", {31'd0, id_stall}, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, i_use5, 1'b0);
        rst_n = 1'b1; #1;
        check("t6_stall_gone", {31'd0, id_stall}, 32'd0);
        check("t6_outs_zero", {8'd0, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd,
                               mem_rd, mem_wr, mem_rd_addr, wb_reg_wr, wb_mux_reg_wr, wb_rd}, 32'd0);
        idle();
        idle();
        idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
